// File: rtl/tx_frame_fifo_pkg.sv
// Shared types for the store-and-forward TX frame FIFO.
// Each RAM entry carries the byte plus its end-of-frame and frame-error marks.
package tx_frame_fifo_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_FRAME,
    WR_DISCARD
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_FRAME
  } rd_state_t;

  typedef struct packed {
    logic  last;
    logic  error;
    byte_t data;
  } entry_t;

endpackage

// File: rtl/tx_frame_fifo_if.sv
// Byte stream bundle: user side (s_*) into the FIFO, MAC side (m_*) out of it.
// slave = FIFO view, master = the view of whoever drives the user stream and the MAC ready.
interface tx_frame_fifo_if;
  import tx_frame_fifo_pkg::*;

  byte_t s_data;
  logic  s_valid;
  logic  s_last;
  logic  s_error;
  logic  s_ready;

  byte_t m_data;
  logic  m_valid;
  logic  m_last;
  logic  m_error;
  logic  m_ready;

  modport slave (
    input  s_data, s_valid, s_last, s_error, m_ready,
    output s_ready, m_data, m_valid, m_last, m_error
  );

  modport master (
    output s_data, s_valid, s_last, s_error, m_ready,
    input  s_ready, m_data, m_valid, m_last, m_error
  );
endinterface

// File: rtl/tx_frame_fifo_ram.sv
// Simple dual-port frame RAM; the registered read port doubles as the MAC output register.
// The read register only advances on i_rd_en, so a stalled output holds its value.
module tx_fifo_ram
  import tx_frame_fifo_pkg::*;
#(
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  entry_t            i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output entry_t            o_rd_data
);

  entry_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)       o_rd_data <= '0;
    else if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/tx_frame_fifo.sv
// Store-and-forward TX byte FIFO: frames are released to the MAC only once committed.
// Build option TX_DROP_ERR_EN: drop errored frames at their last byte instead of forwarding m_error.
module tx_frame_fifo
  import tx_frame_fifo_pkg::*;
#(
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  tx_frame_fifo_if.slave  bus,
  output logic [ADDR_W:0] level,
  output logic [ADDR_W:0] frame_count,
  output logic            drop_pulse
);

  localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(DEPTH);

  wr_state_t       r_wr_state;
  rd_state_t       r_rd_state;
  logic [ADDR_W:0] r_wr_ptr, r_wr_commit, r_rd_ptr, r_frame_count;
  logic            r_err, r_drop, r_m_valid;

  logic   w_full, w_wr_acc, w_commit, w_err_frame;
  logic   w_rd_en, w_m_pop, w_last_pop;
  entry_t w_wr_entry, w_rd_entry;

  assign w_full      = (r_wr_ptr - r_rd_ptr) == DEPTH_P;
  assign bus.s_ready = (r_wr_state == WR_DISCARD) | !w_full;
  assign w_wr_acc    = bus.s_valid & bus.s_ready & (r_wr_state != WR_DISCARD);
  assign w_err_frame = r_err | bus.s_error;

`ifdef TX_DROP_ERR_EN
  assign w_commit   = w_wr_acc & bus.s_last & !w_err_frame;
  assign w_wr_entry = '{last: bus.s_last, error: 1'b0, data: bus.s_data};
`else
  assign w_commit   = w_wr_acc & bus.s_last;
  assign w_wr_entry = '{last: bus.s_last, error: bus.s_last & w_err_frame, data: bus.s_data};
`endif

  // Partial frames are rewound to wr_commit; a frame that alone fills the RAM can never commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_state  <= WR_IDLE;
      r_wr_ptr    <= '0;
      r_wr_commit <= '0;
      r_err       <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      case (r_wr_state)
        WR_IDLE, WR_FRAME: begin
          if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_err    <= bus.s_last ? 1'b0 : w_err_frame;
            if (bus.s_last) begin
              r_wr_state <= WR_IDLE;
              if (w_commit) begin
                r_wr_commit <= r_wr_ptr + 1'b1;
              end else begin
                r_wr_ptr <= r_wr_commit;
                r_drop   <= 1'b1;
              end
            end else begin
              r_wr_state <= WR_FRAME;
            end
          end else if (r_wr_state == WR_FRAME && w_full && r_frame_count == '0) begin
            r_wr_ptr   <= r_wr_commit;
            r_drop     <= 1'b1;
            r_err      <= 1'b0;
            r_wr_state <= WR_DISCARD;
          end
        end
        WR_DISCARD: if (bus.s_valid && bus.s_last) r_wr_state <= WR_IDLE;
        default:    r_wr_state <= WR_IDLE;
      endcase
    end
  end

  // Prefetch: issue a RAM read whenever the output register is empty or being drained.
  assign w_m_pop    = r_m_valid & bus.m_ready;
  assign w_last_pop = w_m_pop & w_rd_entry.last;
  assign w_rd_en    = (r_rd_ptr != r_wr_commit)
                    & (r_rd_state == RD_FRAME | r_frame_count != '0)
                    & (!r_m_valid | bus.m_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_state    <= RD_IDLE;
      r_rd_ptr      <= '0;
      r_m_valid     <= 1'b0;
      r_frame_count <= '0;
    end else begin
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;

      if (w_rd_en)      r_m_valid <= 1'b1;
      else if (w_m_pop) r_m_valid <= 1'b0;

      case (r_rd_state)
        RD_IDLE:  if (w_rd_en) r_rd_state <= RD_FRAME;
        RD_FRAME: if (w_last_pop && !w_rd_en) r_rd_state <= RD_IDLE;
      endcase

      case ({w_commit, w_last_pop})
        2'b10:   r_frame_count <= r_frame_count + 1'b1;
        2'b01:   r_frame_count <= r_frame_count - 1'b1;
        default: r_frame_count <= r_frame_count;
      endcase
    end
  end

  tx_fifo_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
    .i_wr_data (w_wr_entry),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
    .o_rd_data (w_rd_entry)
  );

  assign bus.m_valid = r_m_valid;
  assign bus.m_data  = w_rd_entry.data;
  assign bus.m_last  = w_rd_entry.last;
  assign bus.m_error = w_rd_entry.error;
  assign level       = r_wr_ptr - r_rd_ptr;
  assign frame_count = r_frame_count;
  assign drop_pulse  = r_drop;

endmodule

// File: tb/tb_tx_frame_fifo.sv
// Scoreboard bench: frames that survive (length <= DEPTH, and not errored when dropping is on)
// are queued byte-by-byte; a monitor pops and compares on every MAC transfer.
module tb_tx_frame_fifo;
  import tx_frame_fifo_pkg::*;

  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);
`ifdef TX_DROP_ERR_EN
  localparam bit DROP_ERR = 1'b1;
`else
  localparam bit DROP_ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW:0]   level, frame_count;
  logic          drop_pulse;

  tx_frame_fifo_if bus();

  tx_frame_fifo #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .level       (level),
    .frame_count (frame_count),
    .drop_pulse  (drop_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    byte_t d;
    bit    l;
    bit    e;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0, checks = 0;
  int   cyc = 0;
  int   exp_drops = 0, seen_drops = 0;
  int   rdy_mode = 0;

  always @(posedge clk) cyc++;

  function automatic void check(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // MAC ready pattern: 0 always ready, 1 random, 2 toggle, 3 never ready.
  initial begin
    bus.m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = 1'($urandom_range(0, 1));
        2:       bus.m_ready = ~bus.m_ready;
        default: bus.m_ready = 1'b0;
      endcase
    end
  end

  initial begin : monitor
    bit         stalled = 0, prev_drop = 0;
    logic [9:0] held = '0;
    exp_t       x;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 0;
        prev_drop = 0;
        continue;
      end
      if (stalled) begin
        check("stall_valid", bus.m_valid, 1);
        check("stall_hold", {bus.m_last, bus.m_error, bus.m_data}, held);
      end
      if (drop_pulse) begin
        seen_drops++;
        check("drop_width", prev_drop, 0);
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_byte: got data %0d with nothing expected (cycle %0d)", bus.m_data, cyc);
        end else begin
          x = exp_q.pop_front();
          check("m_data", bus.m_data, x.d);
          check("m_last", bus.m_last, x.l);
          check("m_error", bus.m_error, x.e);
        end
      end
      stalled   = bus.m_valid & !bus.m_ready;
      held      = {bus.m_last, bus.m_error, bus.m_data};
      prev_drop = drop_pulse;
    end
  end

  task automatic send_byte(input byte_t d, input bit l, input bit e, output int t_acc);
    int n = 0;
    bus.s_data  = d;
    bus.s_last  = l;
    bus.s_error = e;
    bus.s_valid = 1'b1;
    @(negedge clk);
    while (!bus.s_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_ready) begin
      $display("FAIL send_timeout: s_ready stuck at 0 (cycle %0d)", cyc);
      $fatal(1, "stimulus stuck");
    end
    t_acc = cyc;
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_error = 1'b0;
  endtask

  // Model: a frame survives iff it fits in the FIFO and (when dropping is on) carries no error.
  task automatic send_frame(input int len, input bit seq, input int err_pos, input bit gaps,
                            output int t_last);
    byte_t d[$];
    bit    has_err = (err_pos >= 0);
    bit    keep    = (len <= DEPTH) && !(DROP_ERR && has_err);
    int    t;
    for (int i = 0; i < len; i++) d.push_back(seq ? byte_t'(i) : byte_t'($urandom));
    if (keep) begin
      for (int i = 0; i < len; i++)
        exp_q.push_back('{d: d[i], l: (i == len - 1), e: (i == len - 1) && has_err});
    end else begin
      exp_drops++;
    end
    for (int i = 0; i < len; i++) begin
      send_byte(d[i], i == len - 1, i == err_pos, t);
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    t_last = t;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check({name, "_frame_count"}, frame_count, 0);
    check({name, "_level"}, level, 0);
    @(posedge clk); #1;
  endtask

  initial begin : main
    int t_last, t_v, k, run, d0;
    bus.s_data  = '0;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_error = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_data", bus.m_data, 0);
    check("rst_m_last", bus.m_last, 0);
    check("rst_m_error", bus.m_error, 0);
    check("rst_level", level, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_drop", drop_pulse, 0);
    check("rst_s_ready", bus.s_ready, 1);
    @(posedge clk); #1;

    // 60-byte frame, MAC always ready: first m_valid two cycles after the last write.
    rdy_mode = 0;
    send_frame(60, 1, -1, 0, t_last);
    @(negedge clk);
    check("t1_frame_count", frame_count, 1);
    k = 0;
    while (!bus.m_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    t_v = cyc;
    check("t1_latency", t_v - t_last, 2);
    wait_drain("t1");

    // Three committed frames stream out with no idle cycle between them.
    rdy_mode = 3;
    for (int f = 0; f < 3; f++) send_frame(16, 0, -1, 0, t_last);
    repeat (4) @(posedge clk);
    #1 rdy_mode = 0;
    k = 0;
    while (!(bus.m_valid && bus.m_ready) && k < 20) begin
      @(negedge clk);
      k++;
    end
    run = 0;
    while (bus.m_valid && bus.m_ready && run < 60) begin
      run++;
      @(negedge clk);
    end
    check("t2_burst_len", run, 48);
    wait_drain("t2");

    // Ready toggling every cycle: the monitor checks hold-while-stalled.
    rdy_mode = 2;
    send_frame(16, 0, -1, 1, t_last);
    wait_drain("t3");

    // Oversized frame is dropped once; a following short frame passes.
    rdy_mode = 1;
    d0 = seen_drops;
    send_frame(100, 1, -1, 0, t_last);
    repeat (3) @(negedge clk);
    check("t4_drops", seen_drops - d0, 1);
    check("t4_level", level, 0);
    @(posedge clk); #1;
    send_frame(10, 0, -1, 0, t_last);
    wait_drain("t4");

    // Errored 20-byte frame.
    rdy_mode = 0;
    d0 = seen_drops;
    send_frame(20, 0, 5, 0, t_last);
    wait_drain("t5");
    check("t5_drops", seen_drops - d0, DROP_ERR ? 1 : 0);

    // Reset while 30 bytes of an uncommitted frame are held.
    d0 = seen_drops;
    for (int i = 0; i < 30; i++) send_byte(byte_t'($urandom), 1'b0, i == 3, t_v);
    @(negedge clk);
    check("t6_level_before", level, 30);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("t6_level", level, 0);
    check("t6_m_valid", bus.m_valid, 0);
    check("t6_s_ready", bus.s_ready, 1);
    check("t6_no_drop", seen_drops - d0, 0);
    @(posedge clk); #1;
    send_frame(12, 1, -1, 0, t_last);
    wait_drain("t6");

    // Random mix of lengths, errors, gaps and MAC backpressure.
    rdy_mode = 1;
    for (int f = 0; f < 40; f++) begin
      int len, ep;
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(65, 90)) : int'($urandom_range(1, 40));
      ep  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      send_frame(len, 0, ep, 1, t_last);
    end
    wait_drain("rand");
    check("total_drops", seen_drops, exp_drops);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
